// File: rtl/clock_mode_sequencer_pkg.sv
// Shared types and constants for the clock mode sequencer.
// FSM state encoding, CPU speed codes and the turbo code mapping.
package clock_mode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_STEP     = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_APPLY    = 3'd5,
    ST_RELEASE  = 3'd6
  } state_e;

  localparam logic [1:0] SPEED_3M5 = 2'd0;
  localparam logic [1:0] SPEED_7M  = 2'd1;
  localparam logic [1:0] SPEED_14M = 2'd2;

  // Code 3 has no clock of its own; it runs at 14 MHz.
  function automatic logic [1:0] turbo_map(input logic [1:0] t);
    logic [1:0] r;
    unique case (t)
      SPEED_3M5: r = SPEED_3M5;
      SPEED_7M:  r = SPEED_7M;
      SPEED_14M: r = SPEED_14M;
      default:   r = SPEED_14M;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_mode_sequencer_if.sv
// Request / PLL / clock-select bundle of the clock mode sequencer.
// master drives requests and PLL ready; slave is the sequencer.
interface clock_mode_sequencer_if;
  logic       req_valid;
  logic [2:0] req_pll_option;
  logic [1:0] req_turbo;
  logic       pll_srdy;
  logic       pll_sstep;
  logic [2:0] pll_state;
  logic [1:0] turbo_enable;
  logic       cpu_hold;
  logic       busy;
  logic       err_timeout;

  modport master (
    output req_valid, req_pll_option, req_turbo, pll_srdy,
    input  pll_sstep, pll_state, turbo_enable,
    input  cpu_hold, busy, err_timeout
  );

  modport slave (
    input  req_valid, req_pll_option, req_turbo, pll_srdy,
    output pll_sstep, pll_state, turbo_enable,
    output cpu_hold, busy, err_timeout
  );
endinterface

// File: rtl/clkseq_timer.sv
// Loadable down-counter shared by the HOLD, WAIT_RDY and SETTLE phases.
// expired is high while the count sits at zero.
module clkseq_timer #(
  parameter int               CNT_W   = 13,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/clock_mode_sequencer.sv
// Parks the CPU, steps the PLL, waits for lock, then switches turbo select.
// Define CLKSEQ_TIMEOUT_RETRY_EN to retry the PLL step once on timeout.
module clock_mode_sequencer
  import clock_mode_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  clock_mode_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETL_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] pll_state_q, pll_state_d;
  logic [1:0] turbo_q, turbo_d;
  logic       sstep_q, sstep_d;
  logic       err_q, err_d;
  logic [2:0] tgt_opt_q, tgt_opt_d;
  logic [1:0] tgt_trb_q, tgt_trb_d;
  logic       pll_chg_q, pll_chg_d;
  logic       pend_vld_q, pend_vld_d;
  logic [2:0] pend_opt_q, pend_opt_d;
  logic [1:0] pend_trb_q, pend_trb_d;
`ifdef CLKSEQ_TIMEOUT_RETRY_EN
  logic       retry_q, retry_d;
`endif

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_exp;

  logic       acc_vld;
  logic [2:0] acc_opt;
  logic [1:0] acc_trb;

  // A fresh strobe overrides an older pending request.
  assign acc_vld = bus.req_valid | pend_vld_q;
  assign acc_opt = bus.req_valid ? bus.req_pll_option : pend_opt_q;
  assign acc_trb = turbo_map(bus.req_valid ? bus.req_turbo : pend_trb_q);

  clkseq_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (HOLD_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_comb begin
    state_d     = state_q;
    pll_state_d = pll_state_q;
    turbo_d     = turbo_q;
    sstep_d     = 1'b0;
    err_d       = err_q;
    tgt_opt_d   = tgt_opt_q;
    tgt_trb_d   = tgt_trb_q;
    pll_chg_d   = pll_chg_q;
    pend_vld_d  = pend_vld_q;
    pend_opt_d  = pend_opt_q;
    pend_trb_d  = pend_trb_q;
`ifdef CLKSEQ_TIMEOUT_RETRY_EN
    retry_d     = retry_q;
`endif
    tmr_load    = 1'b0;
    tmr_val     = HOLD_LD;

    if (bus.req_valid && state_q != ST_IDLE) begin
      pend_vld_d = 1'b1;
      pend_opt_d = bus.req_pll_option;
      pend_trb_d = bus.req_turbo;
    end

    unique case (state_q)
      ST_IDLE: begin
        pend_vld_d = 1'b0;
        if (acc_vld) begin
          tgt_opt_d = acc_opt;
          tgt_trb_d = acc_trb;
          pll_chg_d = (acc_opt != pll_state_q);
          if (acc_opt != pll_state_q || acc_trb != turbo_q) begin
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
`ifdef CLKSEQ_TIMEOUT_RETRY_EN
            retry_d  = 1'b0;
`endif
          end
        end
      end
      ST_HOLD: begin
        if (tmr_exp) begin
          if (pll_chg_q) begin
            state_d     = ST_STEP;
            pll_state_d = tgt_opt_q;
            sstep_d     = 1'b1;
          end else begin
            state_d = ST_APPLY;
            turbo_d = tgt_trb_q;
          end
        end
      end
      ST_STEP: begin
        state_d  = ST_WAIT_RDY;
        tmr_load = 1'b1;
        tmr_val  = TOUT_LD;
      end
      ST_WAIT_RDY: begin
        if (bus.pll_srdy) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETL_LD;
        end else if (tmr_exp) begin
`ifdef CLKSEQ_TIMEOUT_RETRY_EN
          if (!retry_q) begin
            state_d = ST_STEP;
            sstep_d = 1'b1;
            retry_d = 1'b1;
          end else begin
            state_d = ST_APPLY;
            turbo_d = tgt_trb_q;
            err_d   = 1'b1;
          end
`else
          state_d = ST_APPLY;
          turbo_d = tgt_trb_q;
          err_d   = 1'b1;
`endif
        end
      end
      ST_SETTLE: begin
        if (tmr_exp) begin
          state_d = ST_APPLY;
          turbo_d = tgt_trb_q;
        end
      end
      ST_APPLY:   state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Reset lands in HOLD with a forced PLL step: the boot reconfiguration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      pll_state_q <= 3'd0;
      turbo_q     <= SPEED_3M5;
      sstep_q     <= 1'b0;
      err_q       <= 1'b0;
      tgt_opt_q   <= 3'd0;
      tgt_trb_q   <= SPEED_3M5;
      pll_chg_q   <= 1'b1;
      pend_vld_q  <= 1'b0;
      pend_opt_q  <= 3'd0;
      pend_trb_q  <= 2'd0;
`ifdef CLKSEQ_TIMEOUT_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pll_state_q <= pll_state_d;
      turbo_q     <= turbo_d;
      sstep_q     <= sstep_d;
      err_q       <= err_d;
      tgt_opt_q   <= tgt_opt_d;
      tgt_trb_q   <= tgt_trb_d;
      pll_chg_q   <= pll_chg_d;
      pend_vld_q  <= pend_vld_d;
      pend_opt_q  <= pend_opt_d;
      pend_trb_q  <= pend_trb_d;
`ifdef CLKSEQ_TIMEOUT_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.pll_sstep    = sstep_q;
  assign bus.pll_state    = pll_state_q;
  assign bus.turbo_enable = turbo_q;
  assign bus.cpu_hold     = (state_q != ST_IDLE);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_clock_mode_sequencer.sv
// Scoreboard bench for clock_mode_sequencer.
// Expected completions are queued at request time and popped when busy falls.
module tb_clock_mode_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_mode_sequencer_if bus();

  clock_mode_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] opt;
    logic [1:0] trb;
    logic       err;
    int         nstep;
  } exp_t;

`ifdef CLKSEQ_TIMEOUT_RETRY_EN
  localparam int NSTEP_TO = 2;
`else
  localparam int NSTEP_TO = 1;
`endif

  exp_t       sbq[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         srdy_dly = 50;
  logic [2:0] m_opt = 3'd0;
  logic [1:0] m_trb = 2'd0;
  logic       m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_sstep", bus.pll_sstep, 0);
    chk("rst_pll_state", bus.pll_state, 0);
    chk("rst_turbo", bus.turbo_enable, 0);
    chk("rst_cpu_hold", bus.cpu_hold, 1);
    chk("rst_busy", bus.busy, 1);
    chk("rst_err", bus.err_timeout, 0);
  endtask

  // Returns at the negedge of cycle 1 (first cycle after the strobe).
  task automatic req(input logic [2:0] opt, input logic [1:0] trb,
                     input bit to, input bit push);
    exp_t       e;
    logic [1:0] tm;
    tm = (trb == 2'd3) ? 2'd2 : trb;
    if (push && (opt != m_opt || tm != m_trb)) begin
      if (opt != m_opt && to) m_err = 1'b1;
      e.opt   = opt;
      e.trb   = tm;
      e.err   = m_err;
      e.nstep = (opt != m_opt) ? (to ? NSTEP_TO : 1) : 0;
      sbq.push_back(e);
      m_opt = opt;
      m_trb = tm;
    end
    @(negedge clk);
    bus.req_valid      = 1'b1;
    bus.req_pll_option = opt;
    bus.req_turbo      = trb;
    @(negedge clk);
    bus.req_valid      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int run = 0;
    for (int i = 0; i < budget && run < 3; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) run++;
      else run = 0;
    end
    chk("idle_reached", bus.busy, 0);
    chk("sb_drained", sbq.size(), 0);
  endtask

  task automatic wait_sstep();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.pll_sstep === 1'b1) seen = 1'b1;
    end
    chk("sstep_seen", seen, 1);
  endtask

  initial begin
    bus.pll_srdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.pll_sstep === 1'b1 && srdy_dly > 0) begin
        repeat (srdy_dly - 1) @(negedge clk);
        bus.pll_srdy = 1'b1;
        @(negedge clk);
        bus.pll_srdy = 1'b0;
      end
    end
  end

  initial begin
    int   step_cnt = 0;
    logic busy_prev = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        step_cnt  = 0;
        busy_prev = 1'b1;
      end else begin
        if (bus.pll_sstep === 1'b1) begin
          step_cnt++;
          chk("sb_depth_step", sbq.size() != 0, 1);
          if (sbq.size() != 0) chk("sstep_pll_state", bus.pll_state, sbq[0].opt);
        end
        if (busy_prev && bus.busy === 1'b0) begin
          chk("sb_depth_done", sbq.size() != 0, 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("done_pll_state", bus.pll_state, e.opt);
            chk("done_turbo", bus.turbo_enable, e.trb);
            chk("done_err", bus.err_timeout, e.err);
            chk("done_nstep", step_cnt, e.nstep);
          end
          step_cnt = 0;
        end
        busy_prev = bus.busy;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc;
    bus.req_valid      = 1'b0;
    bus.req_pll_option = 3'd0;
    bus.req_turbo      = 2'd0;

    // Boot
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset();
    sbq.push_back('{opt: 3'd0, trb: 2'd0, err: 1'b0, nstep: 1});
    rst = 1'b0;
    wait_idle(500);
    chk("boot_cpu_hold", bus.cpu_hold, 0);
    chk("boot_err", bus.err_timeout, 0);

    // PLL change: latency and stability
    req(3'd5, 2'd0, 1'b0, 1'b1);
    chk("hold_rise", bus.cpu_hold, 1);
    repeat (3) @(negedge clk);
    chk("sstep_early", bus.pll_sstep, 0);
    @(negedge clk);
    chk("sstep_lat", bus.pll_sstep, 1);
    chk("pll_state_5", bus.pll_state, 5);
    @(negedge clk);
    chk("sstep_width", bus.pll_sstep, 0);
    chk("pll_state_hold", bus.pll_state, 5);
    wait_idle(500);

    // Turbo-only change
    req(3'd5, 2'd2, 1'b0, 1'b1);
    hc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 4) chk("turbo_before", bus.turbo_enable, 0);
      if (k == 5) chk("turbo_lat", bus.turbo_enable, 2);
      if (bus.cpu_hold === 1'b1) hc++;
      else break;
    end
    chk("hold_pulse_len", hc, 6);
    wait_idle(100);

    // No-op request stays idle
    req(3'd5, 2'd2, 1'b0, 1'b1);
    chk("noop_busy", bus.busy, 0);
    @(negedge clk);
    chk("noop_busy2", bus.busy, 0);

    // Turbo code 3 maps to 14 MHz
    req(3'd5, 2'd0, 1'b0, 1'b1);
    wait_idle(100);
    req(3'd5, 2'd3, 1'b0, 1'b1);
    wait_idle(100);
    chk("turbo3_map", bus.turbo_enable, 2);

    // Timeout: PLL never ready
    srdy_dly = 0;
    req(3'd3, 2'd1, 1'b1, 1'b1);
    wait_idle(10000);
    chk("timeout_err", bus.err_timeout, 1);
    srdy_dly = 50;

    // Pending slot: last write wins
    req(3'd2, 2'd1, 1'b0, 1'b1);
    wait_sstep();
    req(3'd6, 2'd1, 1'b0, 1'b0);
    req(3'd7, 2'd1, 1'b0, 1'b1);
    wait_idle(500);
    repeat (30) @(negedge clk);
    chk("pend_no_extra", bus.busy, 0);
    chk("pend_final", bus.pll_state, 7);

    // Reset during SETTLE with a pending request
    req(3'd4, 2'd0, 1'b0, 1'b1);
    wait_sstep();
    repeat (8) @(negedge clk);
    req(3'd1, 2'd1, 1'b0, 1'b0);
    repeat (45) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk_reset();
    @(negedge clk);
    m_opt = 3'd0;
    m_trb = 2'd0;
    m_err = 1'b0;
    sbq.push_back('{opt: 3'd0, trb: 2'd0, err: 1'b0, nstep: 1});
    rst = 1'b0;
    wait_idle(500);
    repeat (30) @(negedge clk);
    chk("rst_pend_cleared", bus.busy, 0);
    chk("rst_final_pll", bus.pll_state, 0);
    chk("rst_final_turbo", bus.turbo_enable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
